// File: rtl/alu_arm_pkg.sv
// Shared opcode constants and status-flag bit positions for the ARM data-processing ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_arm_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b0001;
    localparam logic [3:0] OP_EOR = 4'b0010;
    localparam logic [3:0] OP_BIC = 4'b0011;
    localparam logic [3:0] OP_CMP = 4'b0100;
    localparam logic [3:0] OP_CMN = 4'b0101;
    localparam logic [3:0] OP_TST = 4'b0110;
    localparam logic [3:0] OP_TEQ = 4'b0111;
    localparam logic [3:0] OP_MOV = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b1010;
    localparam logic [3:0] OP_ADC = 4'b1011;
    localparam logic [3:0] OP_SUB = 4'b1100;
    localparam logic [3:0] OP_SBC = 4'b1101;
    localparam logic [3:0] OP_RSB = 4'b1110;
    localparam logic [3:0] OP_RSC = 4'b1111;

    // Bit positions inside a packed {N,C,Z,V} flag nibble.
    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_arm_core.sv
// Combinational result and NCZV flag logic for the 16 ARM data-processing opcodes.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: op (opcode), da (Rn), db (shifter operand), cin (C flag / shifter carry),
//        res (result), flags (packed N,C,Z,V at FLAG_* positions).
module alu_arm_core
    import alu_arm_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] da,
    input  logic [31:0] db,
    input  logic        cin,
    output logic [31:0] res,
    output logic [3:0]  flags
);

    logic [31:0] x;
    logic [31:0] y;
    logic        c;
    logic        arith;
    logic [32:0] sum;

    // Operand steering for the single shared adder: subtraction is done as
    // x + ~y + 1 (or + cin for the with-carry forms), reverse forms swap operands.
    always_comb begin
        x     = da;
        y     = db;
        c     = 1'b0;
        arith = 1'b1;
        case (op)
            OP_ADD, OP_CMN: begin end
            OP_ADC: c = cin;
            OP_SUB, OP_CMP: begin y = ~db; c = 1'b1; end
            OP_SBC: begin y = ~db; c = cin; end
            OP_RSB: begin x = db; y = ~da; c = 1'b1; end
            OP_RSC: begin x = db; y = ~da; c = cin; end
            default: arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, x} + {1'b0, y} + {32'b0, c};

    always_comb begin
        case (op)
            OP_AND, OP_TST: res = da & db;
            OP_ORR:         res = da | db;
            OP_EOR, OP_TEQ: res = da ^ db;
            OP_BIC:         res = da & ~db;
            OP_MOV:         res = db;
            OP_MVN:         res = ~db;
            default:        res = sum[31:0];
        endcase
    end

    // Logical/move ops pass the shifter carry through and never overflow.
    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = res[31];
        flags[FLAG_Z] = (res == 32'd0);
        flags[FLAG_C] = arith ? sum[32] : cin;
        flags[FLAG_V] = arith & (x[31] == y[31]) & (res[31] != x[31]);
    end

endmodule

// File: rtl/alu_arm.sv
// Registered 32-bit ARM data-processing ALU: result and N/C/Z/V flags captured every edge.
// Latency: 1 cycle, loaded on every rising CLK; CLR (sync, active-high) wins over new inputs.
// Backpressure: none; no handshake, a new operation may be issued every cycle.
// Ports: out/NF/CF/ZF/VF registered outputs; A opcode; da Rn; db shifter operand;
//        Cin carry in; CLK clock; CLR synchronous reset.
module alu_arm
    import alu_arm_pkg::*;
(
    output logic [31:0] out,
    output logic        NF,
    output logic        CF,
    output logic        ZF,
    output logic        VF,
    input  logic [3:0]  A,
    input  logic [31:0] da,
    input  logic [31:0] db,
    input  logic        Cin,
    input  logic        CLK,
    input  logic        CLR
);

    logic [31:0] res;
    logic [3:0]  flags;

    alu_arm_core u_core (
        .op    (A),
        .da    (da),
        .db    (db),
        .cin   (Cin),
        .res   (res),
        .flags (flags)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            out <= 32'd0;
            NF  <= 1'b0;
            CF  <= 1'b0;
            ZF  <= 1'b0;
            VF  <= 1'b0;
        end else begin
            out <= res;
            NF  <= flags[FLAG_N];
            CF  <= flags[FLAG_C];
            ZF  <= flags[FLAG_Z];
            VF  <= flags[FLAG_V];
        end
    end

endmodule

// File: tb/tb_alu_arm.sv
// Self-checking bench for alu_arm: directed vectors with hand-derived results,
// then randomized operations checked against an integer-arithmetic reference model.
// Flags are compared as a nibble {N,C,Z,V}.
module tb_alu_arm;

    logic [31:0] out;
    logic        NF, CF, ZF, VF;
    logic [3:0]  A;
    logic [31:0] da, db;
    logic        Cin;
    logic        CLK;
    logic        CLR;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arm dut (
        .out (out),
        .NF  (NF),
        .CF  (CF),
        .ZF  (ZF),
        .VF  (VF),
        .A   (A),
        .da  (da),
        .db  (db),
        .Cin (Cin),
        .CLK (CLK),
        .CLR (CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: compute each opcode as plain integer arithmetic on 64-bit values.
    // Carry = unsigned result fits in / exceeds 32 bits; overflow = signed result out of range.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, u, s, bw;
        logic c, v;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        bw = cin ? 0 : 1;
        u = 0; s = 0; c = cin; v = 1'b0; r = 32'd0;
        case (op)
            4'd0, 4'd6: r = a & b;
            4'd1:       r = a | b;
            4'd2, 4'd7: r = a ^ b;
            4'd3:       r = a & ~b;
            4'd8:       r = b;
            4'd9:       r = ~b;
            4'd5, 4'd10: begin u = ua + ub;           s = sa + sb;           end
            4'd11:       begin u = ua + ub + (1 - bw); s = sa + sb + (1 - bw); end
            4'd4, 4'd12: begin u = ua - ub;           s = sa - sb;           end
            4'd13:       begin u = ua - ub - bw;      s = sa - sb - bw;      end
            4'd14:       begin u = ub - ua;           s = sb - sa;           end
            default:     begin u = ub - ua - bw;      s = sb - sa - bw;      end
        endcase
        if (op inside {4'd5, 4'd10, 4'd11}) begin
            r = u[31:0];
            c = (u > 64'sh0000_0000_FFFF_FFFF);
            v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
        end else if (op inside {4'd4, 4'd12, 4'd13, 4'd14, 4'd15}) begin
            r = u[31:0];
            c = (u >= 0);
            v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
        end
        f = {r[31], c, (r == 32'd0), v};
    endfunction

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic clr);
        A = op; da = a; db = b; Cin = cin; CLR = clr;
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] r;
        logic [3:0]  f;   // {N,C,Z,V}
    } vec_t;

    vec_t dir[$];

    initial begin
        logic [31:0] er;
        logic [3:0]  ef;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        cin;

        A = 4'd0; da = 32'd0; db = 32'd0; Cin = 1'b0; CLR = 1'b1;
        @(negedge CLK);

        // Reset with arbitrary inputs on the bus.
        step(4'd11, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1);
        check("reset_out", out, 32'd0);
        check("reset_flags", {28'd0, NF, CF, ZF, VF}, 32'd0);

        // Opcode sweep da=FFFFFFFF db=F0000000 Cin=1.
        dir.push_back('{4'd0,  32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'hF0000000, 4'b1100});
        dir.push_back('{4'd1,  32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'hFFFFFFFF, 4'b1100});
        dir.push_back('{4'd2,  32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'h0FFFFFFF, 4'b0100});
        dir.push_back('{4'd3,  32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'h0FFFFFFF, 4'b0100});
        dir.push_back('{4'd4,  32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'h0FFFFFFF, 4'b0100});
        dir.push_back('{4'd5,  32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'hEFFFFFFF, 4'b1100});
        dir.push_back('{4'd6,  32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'hF0000000, 4'b1100});
        dir.push_back('{4'd7,  32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'h0FFFFFFF, 4'b0100});
        dir.push_back('{4'd8,  32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'hF0000000, 4'b1100});
        dir.push_back('{4'd9,  32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'h0FFFFFFF, 4'b0100});
        dir.push_back('{4'd10, 32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'hEFFFFFFF, 4'b1100});
        dir.push_back('{4'd11, 32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'hF0000000, 4'b1100});
        dir.push_back('{4'd12, 32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'h0FFFFFFF, 4'b0100});
        dir.push_back('{4'd13, 32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'h0FFFFFFF, 4'b0100});
        dir.push_back('{4'd14, 32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'hF0000001, 4'b1000});
        dir.push_back('{4'd15, 32'hFFFFFFFF, 32'hF0000000, 1'b1, 32'hF0000001, 4'b1000});
        // Overflow, equality, borrow, SBC carry-in, logical carry pass-through.
        dir.push_back('{4'd10, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1001});
        dir.push_back('{4'd4,  32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 4'b0110});
        dir.push_back('{4'd12, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 4'b1000});
        dir.push_back('{4'd13, 32'h00000005, 32'h00000003, 1'b0, 32'h00000001, 4'b0100});
        dir.push_back('{4'd13, 32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 4'b0100});
        dir.push_back('{4'd0,  32'h0F0F0F0F, 32'h00FF00FF, 1'b1, 32'h000F000F, 4'b0100});
        dir.push_back('{4'd0,  32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 32'h000F000F, 4'b0000});

        foreach (dir[i]) begin
            step(dir[i].op, dir[i].a, dir[i].b, dir[i].cin, 1'b0);
            check($sformatf("dir%0d_op%0d_out", i, dir[i].op), out, dir[i].r);
            check($sformatf("dir%0d_op%0d_flags", i, dir[i].op), {28'd0, NF, CF, ZF, VF}, {28'd0, dir[i].f});
        end

        // Randomized operations; operands biased toward edge values to hit C/V/Z.
        for (int i = 0; i < 600; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 + 32'h80000000 * 32'($urandom_range(0, 1)) : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a ^ 32'($urandom_range(0, 1)) : $urandom;
            cin = 1'($urandom_range(0, 1));
            if (i % 97 == 50) begin
                // Mid-stream reset discards the in-flight operation.
                step(op, a, b, cin, 1'b1);
                check($sformatf("rnd%0d_clr_out", i), out, 32'd0);
                check($sformatf("rnd%0d_clr_flags", i), {28'd0, NF, CF, ZF, VF}, 32'd0);
            end else begin
                step(op, a, b, cin, 1'b0);
                model(op, a, b, cin, er, ef);
                check($sformatf("rnd%0d_op%0d_out", i, op), out, er);
                check($sformatf("rnd%0d_op%0d_flags", i, op), {28'd0, NF, CF, ZF, VF}, {28'd0, ef});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
